apb_master: RTL and testbench
=============================

# apb_master

Single-requester APB initiator that drives the register bank from a simple command/response port. Accepts one read or write command via a valid/ready handshake, sequences the APB SETUP and ACCESS phases, waits on PREADY, and returns captured read data and error status. Sits between the control sequencer and the APB register slaves. Address decode to individual slave selects happens downstream; this block drives one PSEL.

## Interface
Parameters:
- AWIDTH, 4, APB address width
- DWIDTH, 8, APB data width
- TIMEOUT_CYCLES, 15, maximum wait-state cycles before abort; used only with APB_MASTER_TIMEOUT_EN; range 1..255

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  AWIDTH  target address
- cmd_wdata  in  DWIDTH  write data
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  DWIDTH  read data; 0 for writes and aborted transfers
- rsp_err  out  1  transfer error; qualified by rsp_valid
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  AWIDTH  APB address
- PWDATA  out  DWIDTH  APB write data
- PRDATA  in  DWIDTH  APB read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: cmd_ready = 1. On handshake, register cmd_write/addr/wdata into PWRITE/PADDR/PWDATA, go to SETUP.
- SETUP: PSEL = 1, PENABLE = 0, cmd_ready = 0. Unconditionally go to ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1. If PREADY = 0, stay (wait state). If PREADY = 1: capture PRDATA (reads only; writes return 0) and PSLVERR, then:
  - if cmd_valid, go to SETUP with the new command (back-to-back, no IDLE cycle)
  - otherwise go to IDLE
- cmd_ready = 1 in IDLE, and in ACCESS while PREADY = 1. It is 0 in all other cycles.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the final ACCESS cycle.
- PADDR, PWRITE and PWDATA are don't-care-but-stable in IDLE: they keep their last value.
- rsp_valid pulses in the cycle after the completing ACCESS cycle. rsp_rdata and rsp_err hold their values until the next response.
- The response port has no backpressure. The consumer must sample rsp_* when rsp_valid = 1.
- PRDATA is ignored for writes.

## Timing
- Reset values: state = IDLE; cmd_ready = 1 after reset release; PSEL, PENABLE, PWRITE, rsp_valid and rsp_err = 0; PADDR, PWDATA and rsp_rdata = 0.
- Reset asserted mid-transfer forces IDLE immediately (asynchronous). No response is produced for the aborted command.
- Minimum transfer: handshake at cycle N, SETUP at N+1, ACCESS at N+2 with PREADY = 1, rsp_valid at N+3.
- Each wait state adds one cycle.
- Back-to-back throughput: one transfer per 2 cycles.
- PSEL stays high across back-to-back transfers. PENABLE drops for the one SETUP cycle between them.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer is aborted. The state goes to IDLE; a back-to-back command is not accepted that cycle.
  - The abort response is rsp_valid with rsp_err = 1 and rsp_rdata = 0.
  - If PREADY = 1 on the same cycle the count reaches TIMEOUT_CYCLES, PREADY wins and the transfer completes normally.
- APB_MASTER_TIMEOUT_EN undefined:
  - No counter is present, and the block waits on PREADY indefinitely.
  - rsp_err = captured PSLVERR only.

## Structure
- Shared package apb_pkg holds the state enum (IDLE, SETUP, ACCESS) and width localparams reused by the slave-side register modules.
- Optional sub-module apb_timeout_cnt: the wait counter, instantiated only under APB_MASTER_TIMEOUT_EN.
- The remaining FSM and datapath stay in apb_master.

## Test plan
- Write, addr 0x3, data 0xA5, PREADY tied 1:
  - PSEL at N+1
  - PENABLE at N+2
  - PWDATA = 0xA5 stable through both phases
  - rsp_valid at N+3, rsp_err = 0, rsp_rdata = 0
- Read, addr 0x5, PREADY low for 2 ACCESS cycles, PRDATA = 0x3C: rsp_valid at N+5 with rsp_rdata = 0x3C.
- Two commands held valid back-to-back (write 0x1/0x11, then read 0x2): PSEL never drops, one SETUP cycle between transfers, two rsp_valid pulses 2 cycles apart.
- Read with PSLVERR = 1 on the completing cycle: rsp_err = 1 and the next transfer is unaffected.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 4, PREADY stuck 0:
  - abort after 4 wait cycles
  - PSEL drops
  - rsp_err = 1, rsp_rdata = 0
- PRESET asserted during ACCESS:
  - PSEL, PENABLE and rsp_valid = 0 immediately
  - after release, cmd_ready = 1 and a new write completes normally

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state encoding and default bus widths,
// reused by the initiator and the slave-side register modules.
package apb_pkg;

    localparam int APB_AWIDTH = 4;
    localparam int APB_DWIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command/response port plus APB bus of the single-requester APB initiator.
// Command handshake: a command transfers on a rising PCLK when cmd_valid & cmd_ready are both 1;
// rsp_valid is a one-cycle pulse with no backpressure, rsp_rdata/rsp_err are qualified by it.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int AWIDTH = APB_AWIDTH,
    parameter int DWIDTH = APB_DWIDTH
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [AWIDTH-1:0] PADDR;
    logic [DWIDTH-1:0] PWDATA;
    logic [DWIDTH-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

endinterface

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB initiator: cleared while in SETUP, counts ACCESS cycles
// without PREADY, and flags when the count equals LIMIT.
module apb_timeout_cnt #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic hit
);

    localparam logic [7:0] LIMIT_C = 8'(LIMIT);

    logic [7:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign hit = (count_q == LIMIT_C);

endmodule

// File: rtl/apb_master.sv
// Single-requester APB initiator: one command in, SETUP/ACCESS sequencing, one response out.
// Define APB_MASTER_TIMEOUT_EN to abort transfers that wait more than TIMEOUT_CYCLES.
module apb_master
    import apb_pkg::*;
#(
    parameter int AWIDTH         = APB_AWIDTH,
    parameter int DWIDTH         = APB_DWIDTH,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus,
    output apb_state_e   state_dbg
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be within 1..255");
    end

    apb_state_e        state_q, state_d;
    logic              done, abort, ready, accept;
    logic [AWIDTH-1:0] paddr_q;
    logic [DWIDTH-1:0] pwdata_q, rdata_q;
    logic              pwrite_q, rsp_valid_q, rsp_err_q;

`ifdef APB_MASTER_TIMEOUT_EN
    logic tmo_hit;

    apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_cnt (
        .clk   (PCLK),
        .rst   (PRESET),
        .clear (state_q == SETUP),
        .inc   (state_q == ACCESS && !bus.PREADY),
        .hit   (tmo_hit)
    );

    // PREADY wins over a timeout that expires in the same cycle.
    assign abort = (state_q == ACCESS) && !bus.PREADY && tmo_hit;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        done    = (state_q == ACCESS) && bus.PREADY;
        ready   = (state_q == IDLE) || done;
        accept  = bus.cmd_valid && ready;
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS: begin
                if (done) begin
                    state_d = accept ? SETUP : IDLE;
                end else if (abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address/control/data only load on a handshake, so they stay stable through SETUP,
    // every ACCESS cycle, and the following idle period.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                paddr_q  <= bus.cmd_addr;
                pwrite_q <= bus.cmd_write;
                pwdata_q <= bus.cmd_wdata;
            end
            rsp_valid_q <= done || abort;
            if (done) begin
                rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
                rsp_err_q <= bus.PSLVERR;
            end else if (abort) begin
                rdata_q   <= '0;
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.PSEL      = (state_q != IDLE);
    assign bus.PENABLE   = (state_q == ACCESS);
    assign bus.PADDR     = paddr_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed command lists, a cycle-schedule model of the expected bus
// and response timeline, a per-cycle compare process and literal latency/data pins.
module tb_apb_master;
    import apb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO    = 4;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 15;
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int MAXC = 4096;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] prdata;
        bit            slverr;
        int            present;
    } cmd_t;

    typedef struct {
        int            waits;
        logic [DW-1:0] prdata;
        bit            slverr;
    } slv_t;

    // ---------------- clock / reset / DUT ----------------
    logic       PCLK   = 1'b0;
    logic       PRESET = 1'b1;
    apb_state_e state_dbg;
    int         cyc    = 0;

    apb_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    apb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // ---------------- bookkeeping ----------------
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   checking = 1'b0;
    cmd_t scen[$];
    slv_t slv_q[$];
    int   acc_cnt = 0;
    logic [DW:0] exp_q[$];
    bit            e_psel[MAXC], e_pen[MAXC], e_rdy[MAXC], e_rv[MAXC], e_wr[MAXC];
    logic [AW-1:0] e_addr[MAXC];
    logic [DW-1:0] e_wdata[MAXC];
    int            end_cyc;
    int            hs_log[$], rsp_cyc_log[$], psel_rise_log[$], pen_rise_log[$];
    logic [DW-1:0] rsp_rd_log[$];
    logic          rsp_err_log[$];
    logic          psel_prev = 1'b0, pen_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: actual %0h, required %0h", name, cyc, act, exp);
    endtask

    function automatic cmd_t mk(bit wr, logic [AW-1:0] addr, logic [DW-1:0] wdata, int waits,
                                logic [DW-1:0] prdata, bit slverr, int present);
        cmd_t c;
        c.wr = wr; c.addr = addr; c.wdata = wdata; c.waits = waits;
        c.prdata = prdata; c.slverr = slverr; c.present = present;
        return c;
    endfunction

    function automatic int hs_at(int i);
        return (hs_log.size() > i) ? hs_log[i] : -1000;
    endfunction
    function automatic int rsp_at(int i);
        return (rsp_cyc_log.size() > i) ? rsp_cyc_log[i] : -5000;
    endfunction
    function automatic logic [DW-1:0] rd_at(int i);
        return (rsp_rd_log.size() > i) ? rsp_rd_log[i] : {DW{1'bx}};
    endfunction
    function automatic logic err_at(int i);
        return (rsp_err_log.size() > i) ? rsp_err_log[i] : 1'bx;
    endfunction

    // ---------------- model: expected cycle schedule from the command list ----------------
    task automatic build_model();
        int  prev_c     = -1;
        bit  prev_abort = 1'b0;
        for (int k = 0; k < MAXC; k++) begin
            e_psel[k] = 0; e_pen[k] = 0; e_rdy[k] = 1; e_rv[k] = 0;
            e_wr[k] = 0; e_addr[k] = '0; e_wdata[k] = '0;
        end
        exp_q.delete();
        end_cyc = cyc + 4;
        foreach (scen[i]) begin
            int            h, c, w, floor_c;
            bit            ab;
            logic [DW-1:0] rd;
            floor_c = prev_abort ? prev_c + 1 : prev_c;
            h  = (prev_c < 0 || scen[i].present > floor_c) ? scen[i].present : floor_c;
            ab = TMO_EN && (scen[i].waits > TMO);
            w  = ab ? TMO : scen[i].waits;
            c  = h + 2 + w;
            for (int k = h + 1; k <= c && k < MAXC; k++) begin
                e_psel[k]  = 1;
                e_pen[k]   = (k >= h + 2);
                e_addr[k]  = scen[i].addr;
                e_wr[k]    = scen[i].wr;
                e_wdata[k] = scen[i].wdata;
                if (k < c || ab) e_rdy[k] = 0;
            end
            if (c + 1 < MAXC) e_rv[c + 1] = 1;
            rd = (ab || scen[i].wr) ? '0 : scen[i].prdata;
            exp_q.push_back({(ab || scen[i].slverr), rd});
            prev_c     = c;
            prev_abort = ab;
            end_cyc    = c + 2;
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_scen();
        int base;
        @(posedge PCLK); #1;
        base = cyc + 1;
        foreach (scen[i]) scen[i].present += base;
        slv_q.delete(); acc_cnt = 0;
        hs_log.delete(); rsp_cyc_log.delete(); rsp_rd_log.delete(); rsp_err_log.delete();
        psel_rise_log.delete(); pen_rise_log.delete();
        build_model();
        checking = 1'b1;
        foreach (scen[i]) begin
            int budget = 0;
            while (cyc < scen[i].present) begin @(posedge PCLK); #1; end
            bus.cmd_valid = 1'b1;
            bus.cmd_write = scen[i].wr;
            bus.cmd_addr  = scen[i].addr;
            bus.cmd_wdata = scen[i].wdata;
            forever begin
                @(negedge PCLK);
                if (bus.cmd_ready || budget > 200) break;
                budget++;
            end
            if (!bus.cmd_ready) begin
                chk("handshake_wait", bus.cmd_ready, 1);
                bus.cmd_valid = 1'b0;
                break;
            end
            hs_log.push_back(cyc);
            slv_q.push_back('{waits: scen[i].waits, prdata: scen[i].prdata, slverr: scen[i].slverr});
            @(posedge PCLK); #1;
            bus.cmd_valid = 1'b0;
            bus.cmd_addr  = AW'($urandom);
            bus.cmd_wdata = DW'($urandom);
        end
        while (cyc < end_cyc && cyc < MAXC - 1) begin @(posedge PCLK); #1; end
        @(negedge PCLK); #1;
        checking = 1'b0;
        chk("responses_outstanding", exp_q.size(), 0);
    endtask

    // ---------------- APB slave responder ----------------
    initial forever begin
        @(posedge PCLK); #1;
        if (bus.PSEL && bus.PENABLE && slv_q.size() > 0) begin
            if (acc_cnt >= slv_q[0].waits) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = slv_q[0].prdata;
                bus.PSLVERR = slv_q[0].slverr;
                void'(slv_q.pop_front());
                acc_cnt = 0;
            end else begin
                bus.PREADY  = 1'b0;
                bus.PRDATA  = DW'($urandom);
                bus.PSLVERR = 1'($urandom);
                acc_cnt++;
            end
        end else begin
            bus.PREADY  = 1'b0;
            bus.PRDATA  = DW'($urandom);
            bus.PSLVERR = 1'b0;
        end
    end

    // ---------------- scoreboard / compare ----------------
    initial forever begin
        @(negedge PCLK);
        if (checking && cyc < MAXC) begin
            logic [DW:0] e;
            chk("psel", bus.PSEL, e_psel[cyc]);
            chk("penable", bus.PENABLE, e_pen[cyc]);
            chk("cmd_ready", bus.cmd_ready, e_rdy[cyc]);
            chk("rsp_valid", bus.rsp_valid, e_rv[cyc]);
            if (e_psel[cyc]) begin
                chk("paddr", bus.PADDR, e_addr[cyc]);
                chk("pwrite", bus.PWRITE, e_wr[cyc]);
                chk("pwdata", bus.PWDATA, e_wdata[cyc]);
            end
            if (bus.PSEL && !psel_prev) psel_rise_log.push_back(cyc);
            if (bus.PENABLE && !pen_prev) pen_rise_log.push_back(cyc);
            if (bus.rsp_valid) begin
                rsp_cyc_log.push_back(cyc);
                rsp_rd_log.push_back(bus.rsp_rdata);
                rsp_err_log.push_back(bus.rsp_err);
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", bus.rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_err", bus.rsp_err, e[DW]);
                    chk("rsp_rdata", bus.rsp_rdata, e[DW-1:0]);
                end
            end
        end
        psel_prev = bus.PSEL;
        pen_prev  = bus.PENABLE;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int pres;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", bus.PSEL, 0);
        chk("rst_penable", bus.PENABLE, 0);
        @(posedge PCLK); #3;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_pwrite", bus.PWRITE, 0);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_state", state_dbg, IDLE);

        // Single write, no wait states.
        scen.delete();
        scen.push_back(mk(1, 4'h3, 8'hA5, 0, 8'h5E, 0, 0));
        run_scen();
        chk("t1_psel_at_n1", psel_rise_log.size() > 0 ? psel_rise_log[0] - hs_at(0) : -1, 1);
        chk("t1_penable_at_n2", pen_rise_log.size() > 0 ? pen_rise_log[0] - hs_at(0) : -1, 2);
        chk("t1_rsp_at_n3", rsp_at(0) - hs_at(0), 3);
        chk("t1_rdata", rd_at(0), 8'h00);
        chk("t1_err", err_at(0), 0);

        // Read with two wait states.
        scen.delete();
        scen.push_back(mk(0, 4'h5, 8'h00, 2, 8'h3C, 0, 0));
        run_scen();
        chk("t2_rsp_at_n5", rsp_at(0) - hs_at(0), 5);
        chk("t2_rdata", rd_at(0), 8'h3C);

        // Back-to-back write then read.
        scen.delete();
        scen.push_back(mk(1, 4'h1, 8'h11, 0, 8'hE7, 0, 0));
        scen.push_back(mk(0, 4'h2, 8'h00, 0, 8'h96, 0, 0));
        run_scen();
        chk("t3_hs_gap", hs_at(1) - hs_at(0), 2);
        chk("t3_rsp_gap", rsp_at(1) - rsp_at(0), 2);
        chk("t3_psel_rises", psel_rise_log.size(), 1);
        chk("t3_penable_rises", pen_rise_log.size(), 2);
        chk("t3_rdata", rd_at(1), 8'h96);

        // Slave error on a read, then an unaffected write.
        scen.delete();
        scen.push_back(mk(0, 4'h7, 8'h00, 1, 8'h77, 1, 0));
        scen.push_back(mk(1, 4'h4, 8'h5A, 0, 8'h21, 0, 0));
        run_scen();
        chk("t4_err", err_at(0), 1);
        chk("t4_rdata", rd_at(0), 8'h77);
        chk("t4_next_err", err_at(1), 0);
        chk("t4_next_rdata", rd_at(1), 8'h00);

        // Mixed traffic: varying waits and idle gaps.
        scen.delete();
        pres = 0;
        for (int i = 0; i < 8; i++) begin
            pres += $urandom_range(0, 6);
            scen.push_back(mk(1'($urandom), AW'($urandom), DW'($urandom), $urandom_range(0, 3),
                              DW'($urandom), 1'($urandom), pres));
        end
        run_scen();
        chk("t5_rsp_count", rsp_cyc_log.size(), 8);

`ifdef APB_MASTER_TIMEOUT_EN
        // Stuck slave aborts, a following write runs; a reply exactly at the limit completes.
        scen.delete();
        scen.push_back(mk(0, 4'h9, 8'h00, 1000, 8'hFF, 0, 0));
        scen.push_back(mk(1, 4'hA, 8'h6D, 0, 8'h12, 0, 0));
        scen.push_back(mk(0, 4'hB, 8'h00, TMO, 8'hC3, 0, 0));
        run_scen();
        chk("t6_abort_rsp_at", rsp_at(0) - hs_at(0), 2 + TMO + 1);
        chk("t6_abort_err", err_at(0), 1);
        chk("t6_abort_rdata", rd_at(0), 8'h00);
        chk("t6_psel_rises", psel_rise_log.size(), 2);
        chk("t6_limit_rsp_at", rsp_at(2) - hs_at(2), 2 + TMO + 1);
        chk("t6_limit_err", err_at(2), 0);
        chk("t6_limit_rdata", rd_at(2), 8'hC3);
`endif

        // Reset asserted during ACCESS.
        slv_q.delete(); acc_cnt = 0;
        @(posedge PCLK); #1;
        slv_q.push_back('{waits: 50, prdata: 8'h44, slverr: 1'b0});
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'h6;
        @(negedge PCLK);
        chk("t7_accept", bus.cmd_ready, 1);
        @(posedge PCLK); #1; bus.cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        chk("t7_in_access", bus.PENABLE, 1);
        #2; PRESET = 1'b1; #1;
        chk("t7_rst_psel", bus.PSEL, 0);
        chk("t7_rst_penable", bus.PENABLE, 0);
        chk("t7_rst_rsp_valid", bus.rsp_valid, 0);
        chk("t7_rst_state", state_dbg, IDLE);
        @(posedge PCLK); #3; PRESET = 1'b0;
        @(negedge PCLK);
        chk("t7_ready_after", bus.cmd_ready, 1);
        chk("t7_no_rsp", bus.rsp_valid, 0);
        scen.delete();
        scen.push_back(mk(1, 4'hE, 8'h3C, 0, 8'h99, 0, 0));
        run_scen();
        chk("t7_write_rsp_at", rsp_at(0) - hs_at(0), 3);
        chk("t7_write_err", err_at(0), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
